// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: iterative MULT/DIV sequencer and sole HI/LO write source, with EX-stage stall
module hilo_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] lo_i
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] bm, am, bmag, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] msum, dtry;
  logic neg_p, neg_r, is_div, supp, sa, sb, req, go, mthi, mtlo, wr, last;
  assign req  = resetn & start & ~flush & (state == IDLE);
  assign go   = req & ~op[2];
  assign mthi = req & (op == 3'b100);
  assign mtlo = req & (op == 3'b101);
  assign sa   = ~op[0] & src_a[WIDTH-1];
  assign sb   = ~op[0] & src_b[WIDTH-1];
  assign am   = sa ? -src_a : src_a;
  assign bmag = sb ? -src_b : src_b;
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bm & {WIDTH{acc[0]}}};
  assign dtry = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, bm};
  assign prod = neg_p ? -acc : acc;
  assign quo  = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign wr   = resetn & (state == DONE) & ~supp & ~flush;
  // Output decode: single-cycle moves pass through, iterative results appear only in DONE
  always_comb begin
    stall = resetn & ((state == MUL) | (state == DIV) | go);
    done  = resetn & (state == DONE);
    hi_we = wr | mthi;
    lo_we = wr | mtlo;
    hi_i  = wr ? (is_div ? rem : prod[2*WIDTH-1:WIDTH]) : mthi ? src_a : '0;
    lo_i  = wr ? (is_div ? quo : prod[WIDTH-1:0]) : mtlo ? src_a : '0;
  end
  // Sequencer: latch magnitudes on start, then one shift-add or restoring step per cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      bm     <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      supp   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (go) begin
          cnt    <= '0;
          acc    <= {{WIDTH{1'b0}}, am};
          bm     <= bmag;
          neg_p  <= sa ^ sb;
          neg_r  <= sa;
          is_div <= op[1];
          supp   <= op[1] & (src_b == '0);
          state  <= op[1] ? ((src_b == '0) ? DONE : DIV) : MUL;
        end
        MUL: begin
          acc   <= {msum, acc[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          state <= last ? DONE : MUL;
        end
        DIV: begin
          acc   <= dtry[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {dtry[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          cnt   <= cnt + 1'b1;
          state <= last ? DONE : DIV;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: directed table-driven checks of the HI/LO multiply/divide controller
module tb_hilo_mdu_ctrl;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic stall, done, hi_we, lo_we;
  logic [31:0] hi_i, lo_i;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    logic wr;
    int lat;
  } vec_t;
  vec_t tbl[10];
  hilo_mdu_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .done(done), .hi_we(hi_we), .lo_we(lo_we),
    .hi_i(hi_i), .lo_i(lo_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic idle_zero(input string tag);
    chk({tag, " stall"}, 32'(stall), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " hi_we"}, 32'(hi_we), 0);
    chk({tag, " lo_we"}, 32'(lo_we), 0);
    chk({tag, " hi_i"}, hi_i, 0);
    chk({tag, " lo_i"}, lo_i, 0);
  endtask
  task automatic run(input vec_t v, input int idx);
    int cyc;
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
    #1;
    if (v.lat == 0) begin
      chk({t, " mt stall"}, 32'(stall), 0);
      chk({t, " mt hi_we"}, 32'(hi_we), 32'(v.op == 3'b100));
      chk({t, " mt lo_we"}, 32'(lo_we), 32'(v.op == 3'b101));
      chk({t, " mt hi_i"}, hi_i, v.hi);
      chk({t, " mt lo_i"}, lo_i, v.lo);
      start = 1'b0;
    end else begin
      chk({t, " c0 stall"}, 32'(stall), 1);
      chk({t, " c0 we"}, {30'd0, hi_we, lo_we}, 0);
      chk({t, " c0 data"}, hi_i | lo_i, 0);
      cyc = 0;
      while (cyc < 40) begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
        #1;
        if (done || !stall) break;
      end
      chk({t, " latency"}, 32'(cyc), 32'(v.lat));
      chk({t, " done"}, 32'(done), 1);
      chk({t, " stall"}, 32'(stall), 0);
      chk({t, " hi_we"}, 32'(hi_we), 32'(v.wr));
      chk({t, " lo_we"}, 32'(lo_we), 32'(v.wr));
      chk({t, " hi_i"}, hi_i, v.hi);
      chk({t, " lo_i"}, lo_i, v.lo);
    end
  endtask
  initial begin
    logic seen;
    tbl[0] = '{3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 33};
    tbl[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 33};
    tbl[2] = '{3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 33};
    tbl[3] = '{3'b011, 32'h80000000, 32'd3, 32'h00000002, 32'h2AAAAAAA, 1'b1, 33};
    tbl[4] = '{3'b010, 32'd5, 32'd0, 32'h0, 32'h0, 1'b0, 1};
    tbl[5] = '{3'b101, 32'd5, 32'd0, 32'h0, 32'd5, 1'b1, 0};
    tbl[6] = '{3'b100, 32'h12345678, 32'd0, 32'h12345678, 32'h0, 1'b1, 0};
    tbl[7] = '{3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 33};
    tbl[8] = '{3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, 33};
    tbl[9] = '{3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 33};
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'b100; src_a = 32'hDEADBEEF;
    #1;
    idle_zero("reset");
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) run(tbl[i], i);
    @(negedge clk);
    #1;
    idle_zero("post");
    @(negedge clk);
    start = 1'b1; op = 3'b100; src_a = 32'h12345678; flush = 1'b1;
    #1;
    chk("flush mthi hi_we", 32'(hi_we), 0);
    chk("flush mthi hi_i", hi_i, 0);
    chk("flush mthi stall", 32'(stall), 0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b000; src_a = 32'd5; src_b = 32'd6;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c < 10); op = 3'b100; src_a = 32'hFFFF0000;
      flush = (c == 10);
      #1;
      seen |= hi_we | lo_we | done;
    end
    chk("busy ignores start", 32'(seen), 0);
    chk("flush c10 stall", 32'(stall), 1);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush c11 stall", 32'(stall), 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      #1;
      seen |= hi_we | lo_we | done | stall;
    end
    chk("flush no result", 32'(seen), 0);
    @(negedge clk);
    start = 1'b1; op = 3'b000; src_a = 32'd9; src_b = 32'd9;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre-reset stall", 32'(stall), 1);
    resetn = 1'b0;
    #1;
    chk("async rst stall", 32'(stall), 0);
    chk("async rst we", {30'd0, hi_we, lo_we}, 0);
    @(negedge clk);
    resetn = 1'b1;
    run('{3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 33}, 10);
    @(negedge clk);
    #1;
    idle_zero("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
